// File: rtl/pipe_pkg.sv
// Shared pipeline types and constants for the IF/ID hazard and fetch control.
//   state_e  : controller state (run / waiting on instruction memory)
//   REG_W    : register-index width
//   X0       : zero register index; a write to it never creates a hazard
//   WCNT_W   : width of the instruction-memory wait counter
//   ctrl_t   : bundle of the pipeline control outputs
package pipe_pkg;

  localparam int unsigned REG_W  = 5;
  localparam logic [REG_W-1:0] X0 = 5'd0;
  localparam int unsigned WCNT_W = 16;

  typedef enum logic {
    ST_RUN     = 1'b0,
    ST_WAIT_IM = 1'b1
  } state_e;

  typedef struct packed {
    logic pc_en;
    logic pc_sel;
    logic if_en;
    logic if_flush;
    logic id_bubble;
  } ctrl_t;

endpackage

// File: rtl/if_hazard_ctrl_if.sv
// Pipeline-facing signal bundle of the hazard/fetch controller.
//   master : pipeline side (drives register fields, branch, imem_ready)
//   slave  : controller side (drives PC / IF/ID / ID/EX controls, timeout flag)
interface if_hazard_ctrl_if;
  import pipe_pkg::*;

  logic [REG_W-1:0] rs1_ID;
  logic [REG_W-1:0] rs2_ID;
  logic [REG_W-1:0] rd_EX;
  logic             mem_read_EX;
  logic             branch_taken_EX;
  logic             imem_ready;

  logic             pc_en;
  logic             pc_sel;
  logic             if_en;
  logic             if_flush;
  logic             id_bubble;
  logic             imem_timeout;

  modport master (
    output rs1_ID, rs2_ID, rd_EX, mem_read_EX, branch_taken_EX, imem_ready,
    input  pc_en, pc_sel, if_en, if_flush, id_bubble, imem_timeout
  );

  modport slave (
    input  rs1_ID, rs2_ID, rd_EX, mem_read_EX, branch_taken_EX, imem_ready,
    output pc_en, pc_sel, if_en, if_flush, id_bubble, imem_timeout
  );

endinterface

// File: rtl/if_hazard_detect.sv
// Combinational load-use comparator: a load in EX whose (non-x0) destination
// is read by the instruction in ID.
//   rs1_id, rs2_id : source fields from IF/ID
//   rd_ex          : destination of the instruction in ID/EX
//   mem_read_ex    : ID/EX instruction is a load
//   lu_c           : load-use hazard
module if_hazard_detect
  import pipe_pkg::*;
(
  input  logic [REG_W-1:0] rs1_id,
  input  logic [REG_W-1:0] rs2_id,
  input  logic [REG_W-1:0] rd_ex,
  input  logic             mem_read_ex,
  output logic             lu_c
);

  assign lu_c = mem_read_ex && (rd_ex != X0) &&
                ((rd_ex == rs1_id) || (rd_ex == rs2_id));

endmodule

// File: rtl/if_hazard_ctrl.sv
// Hazard and fetch controller for the IF/ID register and PC. Handles load-use
// stalls, instruction-memory wait states and EX-resolved taken branches.
// Outputs are Mealy (combinational from state and inputs).
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : if_hazard_ctrl_if.slave pipeline bundle
//   stall_cnt  : cycles with if_en=0       (IF_HAZARD_CTRL_PERF_EN only)
//   flush_cnt  : cycles with if_flush=1    (IF_HAZARD_CTRL_PERF_EN only)
// Optional feature macro: IF_HAZARD_CTRL_PERF_EN (performance counters).
module if_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int unsigned IMEM_TIMEOUT = 255,
  parameter int unsigned CNT_W        = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  if_hazard_ctrl_if.slave    bus
`ifdef IF_HAZARD_CTRL_PERF_EN
  ,
  output logic [CNT_W-1:0]   stall_cnt,
  output logic [CNT_W-1:0]   flush_cnt
`endif
);

  localparam logic [WCNT_W-1:0] TMO = WCNT_W'(IMEM_TIMEOUT);

  // Elaboration-time parameter sanity.
  if (IMEM_TIMEOUT < 1 || IMEM_TIMEOUT > 65535 || CNT_W < 1) begin : g_bad_param
    $error("if_hazard_ctrl: IMEM_TIMEOUT must be 1..65535 and CNT_W >= 1");
  end

  state_e            state_q, state_d;
  logic              flush_pend_q, flush_pend_d;
  logic [WCNT_W-1:0] wcnt_q, wcnt_d;
  logic              timeout_q, timeout_d;
  ctrl_t             ctrl_c;
  logic              lu_c;

  if_hazard_detect u_detect (
    .rs1_id      (bus.rs1_ID),
    .rs2_id      (bus.rs2_ID),
    .rd_ex       (bus.rd_EX),
    .mem_read_ex (bus.mem_read_EX),
    .lu_c        (lu_c)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_RUN;
      flush_pend_q <= 1'b0;
      wcnt_q       <= '0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      flush_pend_q <= flush_pend_d;
      wcnt_q       <= wcnt_d;
      timeout_q    <= timeout_d;
    end
  end

  // Next state and Mealy outputs; branch beats imem wait beats load-use.
  always_comb begin
    state_d      = state_q;
    flush_pend_d = flush_pend_q;
    wcnt_d       = wcnt_q;
    timeout_d    = timeout_q;
    ctrl_c       = '0;

    if (!rst_n) begin
      ctrl_c.id_bubble = 1'b1;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (bus.branch_taken_EX) begin
            ctrl_c.pc_en     = 1'b1;
            ctrl_c.pc_sel    = 1'b1;
            ctrl_c.id_bubble = 1'b1;
            if (bus.imem_ready) begin
              ctrl_c.if_en    = 1'b1;
              ctrl_c.if_flush = 1'b1;
            end else begin
              // Fetch of the target is outstanding; squash it once it lands.
              flush_pend_d = 1'b1;
              state_d      = ST_WAIT_IM;
              wcnt_d       = WCNT_W'(1);
            end
          end else if (!bus.imem_ready) begin
            state_d = ST_WAIT_IM;
            wcnt_d  = WCNT_W'(1);
          end else if (lu_c) begin
            ctrl_c.id_bubble = 1'b1;
          end else begin
            ctrl_c.pc_en = 1'b1;
            ctrl_c.if_en = 1'b1;
          end
        end

        ST_WAIT_IM: begin
          // Held ID instruction must not slip into EX alongside its producer.
          ctrl_c.id_bubble = lu_c;
          if (wcnt_q == TMO) begin
            timeout_d = 1'b1;
          end else begin
            wcnt_d = wcnt_q + WCNT_W'(1);
          end
          if (bus.branch_taken_EX) begin
            ctrl_c.pc_en     = 1'b1;
            ctrl_c.pc_sel    = 1'b1;
            ctrl_c.id_bubble = 1'b1;
            flush_pend_d     = 1'b1;
          end
          if (bus.imem_ready) begin
            ctrl_c.pc_en    = 1'b1;
            ctrl_c.if_en    = 1'b1;
            ctrl_c.if_flush = flush_pend_q | bus.branch_taken_EX;
            flush_pend_d    = 1'b0;
            state_d         = ST_RUN;
            wcnt_d          = '0;
          end
        end

        default: state_d = ST_RUN;
      endcase
    end
  end

  assign bus.pc_en        = ctrl_c.pc_en;
  assign bus.pc_sel       = ctrl_c.pc_sel;
  assign bus.if_en        = ctrl_c.if_en;
  assign bus.if_flush     = ctrl_c.if_flush;
  assign bus.id_bubble    = ctrl_c.id_bubble;
  // Sticky register is masked so the flag reads 0 throughout reset.
  assign bus.imem_timeout = timeout_q & rst_n;

`ifdef IF_HAZARD_CTRL_PERF_EN
  logic [CNT_W-1:0] stall_q;
  logic [CNT_W-1:0] flush_q;

  // Free-running, wrapping performance counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (!ctrl_c.if_en)   stall_q <= stall_q + CNT_W'(1);
      if (ctrl_c.if_flush) flush_q <= flush_q + CNT_W'(1);
    end
  end

  assign stall_cnt = rst_n ? stall_q : '0;
  assign flush_cnt = rst_n ? flush_q : '0;
`endif

endmodule

// File: tb/tb_if_hazard_ctrl.sv
// Directed bench for if_hazard_ctrl with a rule-level reference model.
module tb_if_hazard_ctrl;
  import pipe_pkg::*;

  localparam int unsigned TO = 4;
  localparam int unsigned CW = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  if_hazard_ctrl_if bus ();

`ifdef IF_HAZARD_CTRL_PERF_EN
  logic [CW-1:0] stall_cnt;
  logic [CW-1:0] flush_cnt;
`endif

  if_hazard_ctrl #(.IMEM_TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef IF_HAZARD_CTRL_PERF_EN
    ,
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt)
`endif
  );

  int errors = 0;
  int checks = 0;

  // Model state: fetch outstanding, fetched word is stale, WAIT cycles seen,
  // sticky timeout, event counts.
  bit m_wait, m_stale, m_tmo;
  int m_n;
  int m_stalls, m_flushes;

  // Expected outputs of the current cycle.
  bit e_pc_en, e_pc_sel, e_if_en, e_if_flush, e_id_bubble, e_tmo;
  // DUT outputs sampled in the last cycle.
  logic s_pc_en, s_pc_sel, s_if_en, s_if_flush, s_id_bubble, s_tmo;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected outputs from the priority rules: reset, branch, fetch wait,
  // fetch arrival, load-use, normal.
  task automatic model_outputs(input bit rst, input bit br, input bit rdy, input bit lu);
    e_pc_en = 0; e_pc_sel = 0; e_if_en = 0; e_if_flush = 0; e_id_bubble = 0;
    e_tmo = rst ? m_tmo : 1'b0;
    if (!rst) begin
      e_id_bubble = 1;
    end else if (br) begin
      e_pc_en = 1; e_pc_sel = 1; e_id_bubble = 1;
      e_if_en = rdy; e_if_flush = rdy;
    end else if (!rdy) begin
      e_id_bubble = m_wait ? lu : 1'b0;
    end else if (m_wait) begin
      e_pc_en = 1; e_if_en = 1; e_if_flush = m_stale; e_id_bubble = lu;
    end else if (lu) begin
      e_id_bubble = 1;
    end else begin
      e_pc_en = 1; e_if_en = 1;
    end
  endtask

  task automatic model_advance(input bit rst, input bit br, input bit rdy);
    if (!rst) begin
      m_wait = 0; m_stale = 0; m_tmo = 0; m_n = 0; m_stalls = 0; m_flushes = 0;
    end else begin
      if (!e_if_en) m_stalls++;
      if (e_if_flush) m_flushes++;
      if (m_wait) begin
        m_n++;
        if (m_n >= int'(TO)) m_tmo = 1;
      end
      if (rdy) begin
        m_wait = 0; m_stale = 0; m_n = 0;
      end else begin
        m_wait = 1;
        if (br) m_stale = 1;
      end
    end
  endtask

  // One clock: drive, compare at negedge, advance model at posedge.
  task automatic cyc(input bit rst, input bit br, input bit rdy, input bit mr,
                     input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
    bit lu;
    rst_n = rst;
    bus.branch_taken_EX = br;
    bus.imem_ready = rdy;
    bus.mem_read_EX = mr;
    bus.rd_EX = rd;
    bus.rs1_ID = rs1;
    bus.rs2_ID = rs2;
    lu = mr && (rd != 5'd0) && (rd == rs1 || rd == rs2);
    @(negedge clk);
    model_outputs(rst, br, rdy, lu);
    s_pc_en = bus.pc_en; s_pc_sel = bus.pc_sel; s_if_en = bus.if_en;
    s_if_flush = bus.if_flush; s_id_bubble = bus.id_bubble; s_tmo = bus.imem_timeout;
    chk("pc_en", 32'(s_pc_en), 32'(e_pc_en));
    chk("pc_sel", 32'(s_pc_sel), 32'(e_pc_sel));
    chk("if_en", 32'(s_if_en), 32'(e_if_en));
    chk("if_flush", 32'(s_if_flush), 32'(e_if_flush));
    chk("id_bubble", 32'(s_id_bubble), 32'(e_id_bubble));
    chk("imem_timeout", 32'(s_tmo), 32'(e_tmo));
`ifdef IF_HAZARD_CTRL_PERF_EN
    chk("stall_cnt", 32'(stall_cnt), 32'(CW'(m_stalls)));
    chk("flush_cnt", 32'(flush_cnt), 32'(CW'(m_flushes)));
`endif
    @(posedge clk);
    model_advance(rst, br, rdy);
    #1;
  endtask

  // Shorthands: normal traffic with no hazard.
  task automatic run_norm(input bit rdy);
    cyc(1, 0, rdy, 0, 5'd0, 5'd1, 5'd2);
  endtask

  initial begin
    // Reset: reset output values.
    cyc(0, 1, 1, 1, 5'd5, 5'd5, 5'd0);
    chk("lit_rst_bubble", 32'(s_id_bubble), 32'd1);
    chk("lit_rst_pc_en", 32'(s_pc_en), 32'd0);
    cyc(0, 0, 0, 0, 5'd0, 5'd0, 5'd0);

    // First cycle after release obeys RUN rules.
    cyc(1, 0, 1, 1, 5'd3, 5'd1, 5'd2);
    chk("lit_first_pc_en", 32'(s_pc_en), 32'd1);

    // Load-use on rs2: one stall cycle, then normal.
    cyc(1, 0, 1, 1, 5'd5, 5'd7, 5'd5);
    chk("lit_lu_pc_en", 32'(s_pc_en), 32'd0);
    chk("lit_lu_if_en", 32'(s_if_en), 32'd0);
    chk("lit_lu_bubble", 32'(s_id_bubble), 32'd1);
    cyc(1, 0, 1, 0, 5'd0, 5'd7, 5'd5);
    chk("lit_lu_resume", 32'(s_if_en), 32'd1);
    // Load-use on rs1.
    cyc(1, 0, 1, 1, 5'd9, 5'd9, 5'd3);

    // Load to x0 is never a hazard.
    cyc(1, 0, 1, 1, 5'd0, 5'd0, 5'd4);
    chk("lit_x0_pc_en", 32'(s_pc_en), 32'd1);
    chk("lit_x0_if_en", 32'(s_if_en), 32'd1);

    // Branch in RUN with ready; also beats a simultaneous load-use.
    cyc(1, 1, 1, 0, 5'd0, 5'd1, 5'd2);
    chk("lit_br_pc_sel", 32'(s_pc_sel), 32'd1);
    chk("lit_br_flush", 32'(s_if_flush), 32'd1);
    run_norm(1);
    chk("lit_br_after", 32'(s_if_flush), 32'd0);
    cyc(1, 1, 1, 1, 5'd6, 5'd6, 5'd6);

    // Ready low 3 cycles, branch in the 2nd; lu in WAIT bubbles ID.
    run_norm(0);
    cyc(1, 1, 0, 0, 5'd0, 5'd1, 5'd2);
    chk("lit_wbr_pc_en", 32'(s_pc_en), 32'd1);
    chk("lit_wbr_pc_sel", 32'(s_pc_sel), 32'd1);
    cyc(1, 0, 0, 1, 5'd8, 5'd8, 5'd2);
    chk("lit_wlu_bubble", 32'(s_id_bubble), 32'd1);
    run_norm(1);
    chk("lit_wrdy_flush", 32'(s_if_flush), 32'd1);
    chk("lit_wrdy_if_en", 32'(s_if_en), 32'd1);
    run_norm(1);
    chk("lit_back_run", 32'(s_if_flush), 32'd0);

    // Branch while not ready in RUN, then ready: fetched word is squashed.
    cyc(1, 1, 0, 0, 5'd0, 5'd1, 5'd2);
    chk("lit_brnr_if_en", 32'(s_if_en), 32'd0);
    run_norm(1);
    chk("lit_brnr_flush", 32'(s_if_flush), 32'd1);

    // Wait then ready together with a branch; lu on arrival is ignored.
    run_norm(0);
    cyc(1, 1, 1, 0, 5'd0, 5'd1, 5'd2);
    run_norm(0);
    cyc(1, 0, 1, 1, 5'd4, 5'd4, 5'd1);
    chk("lit_warr_lu_if_en", 32'(s_if_en), 32'd1);
    run_norm(1);

    // Timeout: ready low 6 cycles; flag visible after the 4th WAIT cycle.
    run_norm(0);
    repeat (3) run_norm(0);
    run_norm(0);
    chk("lit_tmo_w4", 32'(s_tmo), 32'd0);
    run_norm(0);
    chk("lit_tmo_w5", 32'(s_tmo), 32'd1);
    run_norm(1);
    chk("lit_tmo_sticky", 32'(s_tmo), 32'd1);
    repeat (2) run_norm(1);
    cyc(0, 0, 1, 0, 5'd0, 5'd0, 5'd0);
    chk("lit_tmo_rst", 32'(s_tmo), 32'd0);

    // Reset mid-WAIT with a pending flush discards it.
    run_norm(1);
    run_norm(0);
    cyc(1, 1, 0, 0, 5'd0, 5'd1, 5'd2);
    cyc(0, 0, 0, 0, 5'd0, 5'd1, 5'd2);
    chk("lit_rstw_pc_sel", 32'(s_pc_sel), 32'd0);
    chk("lit_rstw_if_flush", 32'(s_if_flush), 32'd0);
    run_norm(1);
    chk("lit_rstw_flush", 32'(s_if_flush), 32'd0);
    chk("lit_rstw_if_en", 32'(s_if_en), 32'd1);
    repeat (2) run_norm(1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
